// File: rtl/dram_access_ctrl.sv
// dram_access_ctrl: single-outstanding load/store initiator for the data-RAM port.
// Drives dram pins for one ISSUE cycle and returns one response per request.
module dram_access_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int WDATA_W = 24,
    parameter int RDATA_W = 16,
    parameter int RD_LAT  = 1,
    parameter int DEPTH   = 2048
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [WDATA_W-1:0] req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_write,
    output logic               resp_err,
    output logic [RDATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [WDATA_W-1:0] mem_write_data,
    output logic               mem_read_not_write,
    output logic               mem_cs,
    input  logic [RDATA_W-1:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [1:0] cnt;
    logic accept, in_range, last;
    assign req_ready = (state == IDLE) & ~rst;
    assign accept = req_valid & req_ready;
    assign in_range = 32'(req_addr) < DEPTH;
    assign last = cnt == 2'(RD_LAT - 1);
    assign mem_cs = state == ISSUE;
    assign mem_read_not_write = ~(mem_cs & resp_write);
    assign resp_valid = state == RESP;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = accept ? (in_range ? ISSUE : RESP) : IDLE;
            ISSUE:   state_n = resp_write ? RESP : WAIT;
            WAIT:    state_n = last ? RESP : WAIT;
            RESP:    state_n = resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // mem_address/mem_write_data double as the request latch so the dram pins only move on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            resp_write     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state == WAIT) ? cnt + 2'd1 : '0;
            if (accept) begin
                resp_write <= req_write;
                resp_err   <= ~in_range;
                resp_rdata <= '0;
                if (in_range) begin
                    mem_address    <= req_addr;
                    mem_write_data <= req_wdata;
                end
            end
            if (state == WAIT && last)
                resp_rdata <= mem_read_data;
        end
    end
endmodule

// File: tb/tb_dram_access_ctrl.sv
// tb_dram_access_ctrl: directed + randomized checks of dram_access_ctrl against
// a latency-formula reference model and a behavioural dram with RD_LAT read delay.
module tb_dram_access_ctrl;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 1024;
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_ready, req_write = 0;
    logic [10:0] req_addr = '0;
    logic [23:0] req_wdata = '0;
    logic resp_valid, resp_ready = 0, resp_write, resp_err;
    logic [15:0] resp_rdata, mem_read_data;
    logic [10:0] mem_address;
    logic [23:0] mem_write_data;
    logic mem_read_not_write, mem_cs;
    int passed = 0, total = 0;
    logic [23:0] ref_mem [2048];

    dram_access_ctrl #(.ADDR_W(11), .WDATA_W(24), .RDATA_W(16), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_not_write(mem_read_not_write), .mem_cs(mem_cs),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // dram: data sampled on a read edge is valid RD_LAT edges later, noise otherwise
    logic [23:0] dmem [2048];
    logic [15:0] pd [4];
    logic [3:0] pv = '0;
    logic [15:0] noise = 16'h5a5a;
    always @(posedge clk) begin
        if (mem_cs && !mem_read_not_write) dmem[mem_address] <= mem_write_data;
        pv    <= {pv[2:0], mem_cs & mem_read_not_write};
        pd[0] <= dmem[mem_address][15:0];
        for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
        noise <= 16'($urandom);
    end
    assign mem_read_data = pv[RD_LAT-1] ? pd[RD_LAT-1] : noise;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic txn(input logic w, input logic [10:0] a, input logic [23:0] d, input int hold);
        logic err;
        int lat;
        logic [15:0] exp_rd;
        err = 32'(a) >= DEPTH;
        lat = err ? 1 : (w ? 2 : RD_LAT + 2);
        exp_rd = (err || w) ? 16'h0 : ref_mem[a][15:0];
        if (!err && w) ref_mem[a] = d;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        resp_ready = (hold == 0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 0; req_write = 1'($urandom);
                req_addr = 11'($urandom); req_wdata = 24'($urandom);
            end
            chk("mem_cs", mem_cs, c == 1 && !err);
            chk("mem_rnw", mem_read_not_write, (c == 1 && !err) ? !w : 1'b1);
            if (c == 1 && !err) begin
                chk("mem_address", mem_address, a);
                chk("mem_write_data", mem_write_data, d);
            end
            chk("resp_valid_lat", resp_valid, c == lat);
            chk("req_ready_busy", req_ready, 0);
        end
        chk("resp_write", resp_write, w);
        chk("resp_err", resp_err, err);
        chk("resp_rdata", resp_rdata, exp_rd);
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                req_valid = 1; req_write = 1;
                req_addr = 11'($urandom_range(0, 15)); req_wdata = 24'($urandom);
            end
            @(negedge clk);
            chk("resp_valid_hold", resp_valid, 1);
            chk("rdata_hold", resp_rdata, exp_rd);
            chk("err_hold", resp_err, err);
            chk("req_ready_hold", req_ready, 0);
            chk("mem_cs_hold", mem_cs, 0);
        end
        req_valid = 0; resp_ready = 1;
        @(negedge clk);
        chk("resp_valid_done", resp_valid, 0);
        chk("req_ready_done", req_ready, 1);
        resp_ready = 0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin ref_mem[i] = '0; dmem[i] = '0; end
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_rnw", mem_read_not_write, 1);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_write_data, 0);
        chk("rst_resp_fields", {resp_write, resp_err, resp_rdata}, 0);
        rst = 0;
        #1 chk("req_ready_after_rst", req_ready, 1);
        txn(1, 11'd16, 24'd63, 0);
        txn(1, 11'd24, 24'd10, 2);
        txn(0, 11'd16, 24'h0, 0);
        txn(0, 11'd24, 24'h0, 1);
        txn(0, 11'd1500, 24'h0, 1);
        txn(1, 11'd1023, 24'habcdef, 0);
        txn(1, 11'd1024, 24'h123456, 0);
        txn(0, 11'd1023, 24'h0, 0);
        txn(0, 11'd16, 24'h0, 10);
        // reset during WAIT of a load: the aborted load must never respond
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 11'd16;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("wait_no_resp", resp_valid, 0);
        rst = 1; resp_ready = 1;
        @(negedge clk);
        chk("rst_mid_req_ready", req_ready, 0);
        rst = 0;
        #1;
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_mem_cs", mem_cs, 0);
        chk("rst_mid_mem_rnw", mem_read_not_write, 1);
        chk("rst_mid_req_ready_idle", req_ready, 1);
        for (int i = 0; i < RD_LAT + 4; i++) begin
            @(negedge clk);
            chk("aborted_no_resp", resp_valid, 0);
        end
        resp_ready = 0;
        for (int i = 0; i < 16; i++) txn(1, 11'(i), 24'($urandom), 0);
        for (int i = 0; i < 40; i++) begin
            logic [10:0] a;
            a = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1024, 2047)) : 11'($urandom_range(0, 15));
            txn(1'($urandom), a, 24'($urandom), int'($urandom_range(0, 3)));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
- Initiator side of the data-RAM port: accepts load/store requests from the CPU datapath over a valid/ready handshake.
- Drives the dram `address` / `write_data` / `read_not_write` / `cs` pins and captures `read_data` after a fixed read latency.
- Returns one response per request over a second valid/ready handshake.
- Sits between the memory stage and dram; one outstanding transaction at a time.

Parameters:
- ADDR_W, 11, dram address width.
- WDATA_W, 24, dram write-data width.
- RDATA_W, 16, dram read-data width.
- RD_LAT, 1, cycles from the edge dram samples a read until read_data is valid for capture; legal 1..4.
- DEPTH, 2048, number of valid addresses; req_addr >= DEPTH is an error.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  WDATA_W  store data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_write  out  1  echo of req_write for this response
- resp_err  out  1  address out of range; no memory access made
- resp_rdata  out  RDATA_W  load data; 0 for stores and errors
- mem_address  out  ADDR_W  to dram address
- mem_write_data  out  WDATA_W  to dram write_data
- mem_read_not_write  out  1  to dram read_not_write
- mem_cs  out  1  to dram cs
- mem_read_data  in  RDATA_W  from dram read_data

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- req_ready = (state==IDLE) & ~rst. Accept when req_valid & req_ready at an edge; latch write, addr, wdata into request registers.
- IDLE -> ISSUE on accept with addr < DEPTH.
- IDLE -> RESP on accept with addr >= DEPTH. Set resp_err=1, resp_rdata=0. mem_cs never asserts.
- ISSUE lasts exactly one cycle:
  - mem_cs=1; mem_address and mem_write_data from the latched request.
  - mem_read_not_write = ~latched write.
  - Store: ISSUE -> RESP. Load: ISSUE -> WAIT, latency counter cleared.
- WAIT lasts RD_LAT cycles, mem_cs=0. On the edge ending the last WAIT cycle, capture mem_read_data into resp_rdata; -> RESP.
- RESP: resp_valid=1 and all resp_* fields stable until resp_ready. RESP -> IDLE on the edge where resp_ready=1.
- Latency, cycle 1 = the cycle after the accept edge:
  - Store: ISSUE in cycle 1, resp_valid from cycle 2.
  - Load: resp_valid from cycle RD_LAT+2.
  - Error: resp_valid from cycle 1.
- Throughput: at most one request per (latency + 1) cycles; never two accepts without an intervening response handshake.
- Outside ISSUE: mem_cs=0, mem_read_not_write=1. mem_address and mem_write_data hold their last values (no glitching toward dram).
- resp_ready held high while already in RESP: response consumed in its first valid cycle.
- resp_ready low: stall indefinitely in RESP; req_ready stays 0.
- Reset values: state=IDLE, resp_valid=0, resp_write=0, resp_err=0, resp_rdata=0, mem_cs=0, mem_read_not_write=1, mem_address=0, mem_write_data=0, latency counter=0.
- Reset mid-operation:
  - rst at any edge returns to IDLE and drops any pending response; no response is ever produced for the aborted request.
  - A store whose ISSUE cycle coincides with the reset edge has already been presented to dram and is not undone.
- req_valid while not ready: ignored. The requester must hold the request until accepted.

Test Plan:
- Reset, then store addr=16 wdata=63 -> mem_cs=1, mem_read_not_write=0, mem_address=16, mem_write_data=63 for exactly one cycle; resp_valid in cycle 2 with resp_write=1, resp_err=0, resp_rdata=0.
- Store addr=24 wdata=10, then load addr=16 with RD_LAT=1 -> load ISSUE shows mem_read_not_write=1, mem_address=16; resp_valid in cycle 3 with resp_rdata=63; load addr=24 -> 10.
- RD_LAT=3, load addr=16 after storing 63 -> resp_valid in cycle 5, resp_rdata=63; mem_cs high only in cycle 1.
- DEPTH=1024, load addr=1500 -> mem_cs never asserts; resp_valid in cycle 1 with resp_err=1, resp_rdata=0.
- Hold resp_ready=0 for 10 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0 throughout, a second req_valid is not accepted; then resp_ready=1 for one cycle -> IDLE, next request accepted on the following edge.
- Assert rst during WAIT of a load -> next cycle state IDLE, resp_valid=0, mem_cs=0, mem_read_not_write=1; no response for the aborted load appears afterward.
